// File: rtl/sum8_lookahead.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sum8_lookahead                                           |
// | Description : Registered 8-bit carry-lookahead adder built from two    |
// |               4-bit CLA groups, with a running count of output-bit     |
// |               toggles on the registered {co,sum}.                      |
// | Ports       : clk        - clock, rising-edge active                   |
// |               reset_L    - asynchronous active-low reset               |
// |               a, b       - 8-bit unsigned operands                     |
// |               ci         - carry-in                                    |
// |               sum        - registered sum [7:0]                        |
// |               co         - registered carry-out                        |
// |               trans_cnt  - accumulated toggle count of {co,sum},       |
// |                            wraps modulo 2^32                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sum8_lookahead #(
    parameter int PWR_C = 0
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        ci,
    output logic [7:0]  sum,
    output logic        co,
    output logic [31:0] trans_cnt
);

    // PWR_C only tags this instance for power-analysis tooling; folding it
    // in with a zero weight keeps it referenced without changing any width.
    localparam int c_CNT_W = 32 + 0 * PWR_C;

    // One 4-bit CLA group. Result layout: {P, G, c[3:0]} where c[i] is the
    // carry into bit i of the group (c[0] is the group carry-in). Every
    // carry is a flat sum of products, so there is no ripple inside a group.
    function automatic logic [5:0] cla4(input logic [3:0] g,
                                        input logic [3:0] p,
                                        input logic       cin);
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;
        c[0]  = cin;
        c[1]  = g[0] | (p[0] & cin);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        return {grp_p, grp_g, c};
    endfunction

    logic [7:0]         w_g;
    logic [7:0]         w_p;
    logic [5:0]         w_grp0;
    logic [5:0]         w_grp1;
    logic               w_c4;
    logic [7:0]         w_carry;
    logic [7:0]         sum_d;
    logic               co_d;
    logic [3:0]         w_toggles;
    logic [c_CNT_W-1:0] trans_cnt_d;

    logic [7:0]         sum_q;
    logic               co_q;
    logic [c_CNT_W-1:0] trans_cnt_q;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_grp0  = cla4(w_g[3:0], w_p[3:0], ci);
        // Carry into the upper group comes straight from the lower group's
        // G/P and ci, not from the lower group's internal bit-3 carry.
        w_c4    = w_grp0[4] | (w_grp0[5] & ci);
        w_grp1  = cla4(w_g[7:4], w_p[7:4], w_c4);
        w_carry = {w_grp1[3:0], w_grp0[3:0]};
        sum_d   = w_p ^ w_carry;
        co_d    = w_grp1[4] | (w_grp1[5] & w_grp0[4])
                | (w_grp1[5] & w_grp0[5] & ci);
    end

    // Number of bits of the registered {co,sum} that flip on this edge.
    always_comb begin
        logic [8:0] diff;
        diff      = {co_q, sum_q} ^ {co_d, sum_d};
        w_toggles = 4'd0;
        for (int i = 0; i < 9; i++) begin
            w_toggles = w_toggles + {3'd0, diff[i]};
        end
        trans_cnt_d = trans_cnt_q + {{(c_CNT_W-4){1'b0}}, w_toggles};
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sum_q       <= 8'h00;
            co_q        <= 1'b0;
            trans_cnt_q <= '0;
        end else begin
            sum_q       <= sum_d;
            co_q        <= co_d;
            trans_cnt_q <= trans_cnt_d;
        end
    end

    assign sum       = sum_q;
    assign co        = co_q;
    assign trans_cnt = trans_cnt_q[31:0];

endmodule
`default_nettype wire

// File: tb/tb_sum8_lookahead.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sum8_lookahead                                        |
// | Description : Directed and random self-checking bench for the          |
// |               registered 8-bit CLA adder and its toggle counter.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_sum8_lookahead;

    logic        clk;
    logic        reset_L;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [7:0]  sum;
    logic        co;
    logic [31:0] trans_cnt;

    int          n_checks;
    int          n_errors;
    logic [8:0]  m_prev;
    logic [31:0] m_cnt;

    sum8_lookahead #(.PWR_C(0)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sum       (sum),
        .co        (co),
        .trans_cnt (trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_sum,
                             input logic e_co, input logic [31:0] e_cnt);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, e_sum});
        check({tag, "_co"},  {31'd0, co},  {31'd0, e_co});
        check({tag, "_cnt"}, trans_cnt,    e_cnt);
    endtask

    // Drive operands, let one rising edge pass, then update the reference.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tci);
        logic [8:0] res;
        a  = ta;
        b  = tb;
        ci = tci;
        @(posedge clk);
        #1;
        res    = {1'b0, ta} + {1'b0, tb} + {8'd0, tci};
        m_cnt  = m_cnt + $countones(res ^ m_prev);
        m_prev = res;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        check_all("rst_hold", 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        m_prev  = 9'h000;
        m_cnt   = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_prev   = 9'h000;
        m_cnt    = 32'h0;
        reset_L  = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        ci       = 1'b0;

        // Reset state before any clock edge.
        #2;
        check_all("reset0", 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        reset_L = 1'b1;

        // All-zero operands for three cycles.
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'h00, 1'b0);
            check_all("zeros", 8'h00, 1'b0, 32'h0);
        end

        // Full carry out of 0xFF+0x01, then 0x55+0xAA.
        do_reset();
        step(8'hFF, 8'h01, 1'b0);
        check_all("ff_p_01", 8'h00, 1'b1, 32'd1);
        step(8'h55, 8'hAA, 1'b0);
        check_all("55_p_aa", 8'hFF, 1'b0, 32'd10);

        // Carry across the group boundary; full propagate chain with ci.
        step(8'h0F, 8'h01, 1'b0);
        check({"grp_bnd", "_sum"}, {24'd0, sum}, 32'h10);
        check({"grp_bnd", "_co"},  {31'd0, co},  32'h0);
        check("grp_bnd_cnt", trans_cnt, m_cnt);
        step(8'h7F, 8'h80, 1'b1);
        check({"prop_ci", "_sum"}, {24'd0, sum}, 32'h00);
        check({"prop_ci", "_co"},  {31'd0, co},  32'h1);
        check("prop_ci_cnt", trans_cnt, m_cnt);
        step(8'hFF, 8'hFF, 1'b1);
        check_all("ff_ff_ci", 8'hFF, 1'b1, m_cnt);

        // Random sweep against the reference sum and toggle accumulation.
        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            step(ra, rb, 1'b0);
            check("rand_res", {23'd0, co, sum}, {23'd0, m_prev});
            check("rand_cnt", trans_cnt, m_cnt);
        end

        // Asynchronous reset between edges after a nonzero result.
        step(8'hC3, 8'h5A, 1'b1);
        check_all("pre_async", 8'h1E, 1'b1, m_cnt);
        #2;
        reset_L = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 32'h0);
        a = 8'hAB;
        b = 8'hCD;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held", 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        m_prev  = 9'h000;
        m_cnt   = 32'h0;
        step(8'h12, 8'h34, 1'b0);
        check_all("post_rst", 8'h46, 1'b0, m_cnt);

        // Alternating 0xFF/0x00 adds exactly eight toggles per cycle.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(((k % 2) == 1) ? 8'hFF : 8'h00, 8'h00, 1'b0);
            check("alt_cnt", trans_cnt, 32'(8 * k));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    // Hard ceiling so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
